// File: rtl/uart_pkg.sv
// Shared UART definitions: default widths and the byte type used by uart_rx, uart_tx
// and the receive FIFO.
package uart_pkg;
    localparam int unsigned UART_DBIT    = 8;
    localparam int unsigned UART_FIFO_AW = 4;

    typedef logic [UART_DBIT-1:0] uart_byte_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-host buffer bus: push side from the UART receiver, pop and status side
// toward the host.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int unsigned DBIT   = UART_DBIT,
    parameter int unsigned ADDR_W = UART_FIFO_AW
);
    logic              wr_tick;
    logic [DBIT-1:0]   wr_data;
    logic              rd_en;
    logic [DBIT-1:0]   rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              overrun;
    logic              ovr_clr;

    modport slave (
        input  wr_tick, wr_data, rd_en, ovr_clr,
        output rd_data, rd_valid, empty, full, almost_full, count, overrun
    );

    modport master (
        output wr_tick, wr_data, rd_en, ovr_clr,
        input  rd_data, rd_valid, empty, full, almost_full, count, overrun
    );
endinterface

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage for the receive FIFO: synchronous write, registered read.
// Read-during-write to the same address returns the old contents.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DBIT   = UART_DBIT,
    parameter int unsigned ADDR_W = UART_FIFO_AW
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DBIT-1:0]   i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DBIT-1:0]   o_rd_data
);
    logic [DBIT-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Only the output register is reset; the array stays free to map onto RAM.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_data <= '0;
        end else if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: never back-pressures the receiver, drops
// bytes when full and records that in a sticky overrun flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DBIT     = UART_DBIT,
    parameter int unsigned ADDR_W   = UART_FIFO_AW,
    parameter int unsigned AF_LEVEL = 12
) (
    input  logic clk,
    input  logic rst_n,
    uart_rx_fifo_if.slave bus
);
    localparam logic [ADDR_W:0] AF_CNT = AF_LEVEL[ADDR_W:0];

    logic [ADDR_W:0]  r_wr_ptr;
    logic [ADDR_W:0]  r_rd_ptr;
    logic             r_rd_valid;
    logic             r_overrun;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [ADDR_W:0]  w_count;
    logic [DBIT-1:0]  w_rd_data;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                     (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);
    assign w_count = r_wr_ptr - r_rd_ptr;

    // A pop in the same cycle frees the slot the push lands in, so full alone never blocks.
    assign w_pop  = bus.rd_en & ~w_empty;
    assign w_push = bus.wr_tick & (~w_full | w_pop);
    assign w_drop = bus.wr_tick & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_rd_valid <= w_pop;
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    uart_fifo_mem #(
        .DBIT   (DBIT),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
        .i_wr_data (bus.wr_data),
        .i_rd_en   (w_pop),
        .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data (w_rd_data)
    );

    assign bus.rd_data     = w_rd_data;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.empty       = w_empty;
    assign bus.full        = w_full;
    assign bus.almost_full = (w_count >= AF_CNT);
    assign bus.count       = w_count;
    assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue-based model predicts contents and flags,
// a negedge monitor compares every cycle and checks popped bytes in order.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int AFL   = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DBIT(8), .ADDR_W(4)) bus ();

    uart_rx_fifo #(.DBIT(8), .ADDR_W(4), .AF_LEVEL(AFL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit done = 1'b0;

    uart_byte_t m_q[$];
    uart_byte_t sb_q[$];
    uart_byte_t m_last;
    bit         m_valid;
    bit         m_ovr;

    logic       s_wr, s_rd, s_clr;
    uart_byte_t s_data;

    assign bus.wr_tick = s_wr;
    assign bus.wr_data = s_data;
    assign bus.rd_en   = s_rd;
    assign bus.ovr_clr = s_clr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        sb_q.delete();
        m_last  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // Applied at each rising edge, using the inputs that were present before it.
    task automatic model_edge();
        bit pop, push;
        if (!rst_n) return;
        pop  = s_rd && (m_q.size() > 0);
        push = s_wr && ((m_q.size() < DEPTH) || pop);
        if (pop) begin
            m_last = m_q.pop_front();
            sb_q.push_back(m_last);
        end
        if (push) m_q.push_back(s_data);
        if (s_wr && !push) m_ovr = 1'b1;
        else if (s_clr)    m_ovr = 1'b0;
        m_valid = pop;
    endtask

    task automatic step(input logic wr, input uart_byte_t d, input logic rd, input logic clr);
        s_wr = wr; s_data = d; s_rd = rd; s_clr = clr;
        @(posedge clk);
        model_edge();
        #1;
        s_wr = 1'b0; s_rd = 1'b0; s_clr = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    // Monitor: status every cycle, popped bytes against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!done) begin
                chk("count", 32'(bus.count), 32'(m_q.size()));
                chk("empty", 32'(bus.empty), 32'(m_q.size() == 0));
                chk("full", 32'(bus.full), 32'(m_q.size() == DEPTH));
                chk("almost_full", 32'(bus.almost_full), 32'(m_q.size() >= AFL));
                chk("overrun", 32'(bus.overrun), 32'(m_ovr));
                chk("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
                chk("rd_data_hold", 32'(bus.rd_data), 32'(m_last));
                if (bus.rd_valid) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_pop", 32'(bus.rd_data), 32'hFFFF_FFFF);
                    end else begin
                        chk("pop_data", 32'(bus.rd_data), 32'(sb_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        s_wr = 1'b0; s_rd = 1'b0; s_clr = 1'b0; s_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_empty", 32'(bus.empty), 32'd1);
        chk("reset_count", 32'(bus.count), 32'd0);
        chk("reset_rd_data", 32'(bus.rd_data), 32'd0);
        chk("reset_overrun", 32'(bus.overrun), 32'd0);

        // In-order pops of three bytes
        step(1'b1, 8'h41, 1'b0, 1'b0);
        step(1'b1, 8'h42, 1'b0, 1'b0);
        step(1'b1, 8'h43, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            step(1'b0, 8'h00, 1'b0, 1'b0);
        end

        // Fill to full, one dropped byte, drain
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("overrun_after_drop", 32'(bus.overrun), 32'd1);
        drain(DEPTH);

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        chk("full_swap_count", 32'(bus.count), 32'd16);
        drain(DEPTH);

        // Overrun set beats clear, then clear alone
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b1);
        chk("ovr_set_wins", 32'(bus.overrun), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovr_cleared", 32'(bus.overrun), 32'd0);
        drain(11);

        // Asynchronous reset with 5 bytes stored
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_reset_count", 32'(bus.count), 32'd0);
        chk("async_reset_empty", 32'(bus.empty), 32'd1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Empty with simultaneous push and pop
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        chk("empty_swap_count", 32'(bus.count), 32'd1);
        chk("empty_swap_no_valid", 32'(bus.rd_valid), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("empty_swap_pop", 32'(bus.rd_data), 32'h5A);

        // Randomized traffic in phases of varying fill pressure
        for (int ph = 0; ph < 6; ph++) begin
            int wp, rp;
            wp = (ph % 2 == 0) ? 70 : 30;
            rp = (ph % 2 == 0) ? 30 : 70;
            for (int i = 0; i < 400; i++) begin
                step(1'($urandom_range(99) < wp), 8'($urandom),
                     1'($urandom_range(99) < rp), 1'($urandom_range(99) < 5));
            end
        end
        drain(DEPTH + 1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
